// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and counter sizing helper.
package seq_shift_add_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must be able to hold values 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Start/done handshake and operand/result bus of the shift-and-add multiplier.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_shift_add_mult_shift_add_step.sv
// One combinational shift-and-add step: conditionally adds the shifted
// multiplicand into the accumulator.
module seq_shift_add_mult_shift_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic               i_bit,
  output logic [2*WIDTH-1:0] o_acc
);

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    o_acc = i_acc;
    if (i_bit) begin
      o_acc = i_acc + i_mcand;
    end else begin
      o_acc = i_acc;
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: WIDTH RUN cycles per product,
// start/done handshake, result held until the next accepted start.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  seq_shift_add_mult_if.slave  io_bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   w_acc_next;

  seq_shift_add_mult_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[0]),
    .o_acc   (w_acc_next)
  );

  // FSM and datapath; the illegal encoding falls through to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= {(2*WIDTH){1'b0}};
      r_mplier  <= {WIDTH{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, io_bus.a};
            r_mplier <= io_bus.b;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          // Last bit is being processed now, so the step output is the product.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state   <= ST_DONE;
            r_product <= w_acc_next;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_state   <= ST_RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.product = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult at WIDTH=4 and WIDTH=8 against
// a plain a*b reference with a WIDTH+1 edge start-to-done latency.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_shift_add_mult_if #(.WIDTH(4)) bus4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) bus8 ();

  seq_shift_add_mult #(.WIDTH(4)) u_dut4 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus4)
  );

  seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (w == 4) begin
      bus4.start = st;
      bus4.a     = a[3:0];
      bus4.b     = b[3:0];
    end else begin
      bus8.start = st;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
    end
  endtask

  function automatic logic [63:0] prod_of(input int w);
    return (w == 4) ? 64'(bus4.product) : 64'(bus8.product);
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 4) ? bus4.busy : bus8.busy;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? bus4.done : bus8.done;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full operation; optionally pokes start mid-RUN, which must be ignored.
  task automatic do_mult(input int w, input logic [31:0] a, input logic [31:0] b, input logic poke);
    logic [63:0] exp_p;
    logic [63:0] prev_p;
    logic        busy_ok;
    logic        hold_ok;
    int          lat;
    string       tag;
    exp_p   = {32'd0, a} * {32'd0, b};
    prev_p  = prod_of(w);
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    tag     = $sformatf("w%0d %0d*%0d", w, a, b);
    drive(w, 1'b1, a, b);
    step();
    lat = 1;
    while (!done_of(w) && lat < 40) begin
      if (busy_of(w) !== 1'b1) busy_ok = 1'b0;
      if (prod_of(w) !== prev_p) hold_ok = 1'b0;
      drive(w, poke && (lat == 2), $urandom(), $urandom());
      step();
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'(w + 1));
    check_val({tag, " done"}, 64'(done_of(w)), 64'd1);
    check_val({tag, " busy_at_done"}, 64'(busy_of(w)), 64'd0);
    check_val({tag, " product"}, prod_of(w), exp_p);
    check_val({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    check_val({tag, " hold_run"}, 64'(hold_ok), 64'd1);
    drive(w, 1'b0, $urandom(), $urandom());
    step();
    check_val({tag, " done_pulse"}, 64'(done_of(w)), 64'd0);
    check_val({tag, " busy_after"}, 64'(busy_of(w)), 64'd0);
    check_val({tag, " product_held"}, prod_of(w), exp_p);
  endtask

  initial begin
    int lat;
    int n_done;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(4, 1'b0, 32'd0, 32'd0);
    drive(8, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst busy4", 64'(bus4.busy), 64'd0);
    check_val("rst done4", 64'(bus4.done), 64'd0);
    check_val("rst prod4", prod_of(4), 64'd0);
    check_val("rst prod8", prod_of(8), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    check_val("idle busy4", 64'(bus4.busy), 64'd0);
    check_val("idle done4", 64'(bus4.done), 64'd0);
    check_val("idle prod4", prod_of(4), 64'd0);

    do_mult(4, 32'd13, 32'd2, 1'b0);
    do_mult(4, 32'd15, 32'd15, 1'b0);
    do_mult(4, 32'd0, 32'd9, 1'b0);
    do_mult(4, 32'd6, 32'd11, 1'b1);

    // start held high: back-to-back operations every WIDTH+1 cycles
    drive(4, 1'b1, 32'd3, 32'd5);
    step();
    drive(4, 1'b1, 32'd7, 32'd7);
    lat = 1;
    while (!bus4.done && lat < 40) begin
      step();
      lat++;
    end
    check_val("b2b first latency", 64'(lat), 64'd5);
    check_val("b2b first product", prod_of(4), 64'd15);
    step();
    lat = 1;
    while (!bus4.done && lat < 40) begin
      step();
      lat++;
    end
    check_val("b2b second period", 64'(lat), 64'd5);
    check_val("b2b second product", prod_of(4), 64'd49);
    drive(4, 1'b0, 32'd0, 32'd0);
    step();
    check_val("b2b busy_after", 64'(bus4.busy), 64'd0);
    check_val("b2b done_after", 64'(bus4.done), 64'd0);

    // reset during the second RUN cycle discards the operation
    drive(4, 1'b1, 32'd9, 32'd11);
    step();
    drive(4, 1'b0, 32'd0, 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midrst busy", 64'(bus4.busy), 64'd0);
    check_val("midrst done", 64'(bus4.done), 64'd0);
    check_val("midrst product", prod_of(4), 64'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus4.done) n_done++;
      step();
    end
    check_val("midrst no_done", 64'(n_done), 64'd0);
    do_mult(4, 32'd9, 32'd11, 1'b0);

    for (int i = 0; i < 256; i++) begin
      do_mult(4, 32'(i / 16), 32'(i % 16), 1'b0);
    end

    do_mult(8, 32'd255, 32'd255, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      do_mult(8, $urandom_range(0, 255), $urandom_range(0, 255), (i % 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
